// File: rtl/main_memory.sv
// main_memory: word-addressed RAM behind the MDR/RAM shared data wire.
// Reads and writes complete after WAIT_STATES wait cycles. Completion is
// signalled by a one-cycle mm_ready. A 4-phase handshake through HOLD means
// a request that is still held after completion does not start again.
module main_memory #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] mar_addr,
  inout  wire  [DATA_WIDTH-1:0] mm_data,
  input  logic                  read_from_MM,
  input  logic                  write_to_MM,
  output logic                  mm_busy,
  output logic                  mm_ready,
  output logic                  mm_error
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR_WAIT,
    RD_DATA,
    WR_DONE,
    HOLD
  } state_t;

  state_t                state, state_d;
  logic [CW-1:0]         cnt, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic                  drive_en;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // State register and captured address/data. Synchronous active-high reset.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      addr_q <= '0;
      data_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      addr_q <= addr_d;
      data_q <= data_d;
      err_q  <= err_d;
    end
  end

  // Next-state, countdown and commit decode.
  // NOTE: every variable gets a default before the case so no path leaves
  // one unassigned, which would infer a latch.
  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    addr_d    = addr_q;
    data_d    = data_q;
    err_d     = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = addr_q;
    mem_wdata = data_q;
    case (state)
      IDLE: begin
        if (read_from_MM && write_to_MM) begin
          err_d   = 1'b1;
          state_d = HOLD;
        end else if (read_from_MM) begin
          addr_d = mar_addr;
          if (WAIT_STATES == 0) begin
            state_d = RD_DATA;
          end else begin
            state_d = RD_WAIT;
            cnt_d   = CW'(WAIT_STATES);
          end
        end else if (write_to_MM) begin
          addr_d = mar_addr;
          data_d = mm_data;
          if (WAIT_STATES == 0) begin
            mem_we    = 1'b1;
            mem_waddr = mar_addr;
            mem_wdata = mm_data;
            state_d   = WR_DONE;
          end else begin
            state_d = WR_WAIT;
            cnt_d   = CW'(WAIT_STATES);
          end
        end
      end
      RD_WAIT: begin
        if (!read_from_MM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CW'(1)) begin
          state_d = RD_DATA;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      WR_WAIT: begin
        // An abort in the final wait cycle wins over the commit.
        if (!write_to_MM) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt == CW'(1)) begin
          mem_we  = 1'b1;
          state_d = WR_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      RD_DATA, WR_DONE: state_d = HOLD;
      HOLD: begin
        if (!read_from_MM && !write_to_MM) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Storage array write port; a write in progress is dropped on reset.
  // NOTE: the array has no reset branch so it maps onto plain RAM; reset only
  // blocks the commit that would otherwise happen on the reset edge.
  always_ff @(posedge clk) begin
    if (!reset && mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Status outputs come straight from registered state.
  assign mm_busy  = (state != IDLE);
  assign mm_ready = (state == RD_DATA) || (state == WR_DONE);
  assign mm_error = err_q;

  // Drive the shared wire only while the read is still requested, and never
  // while the MDR side may be driving a write.
  assign drive_en = (state == RD_DATA) && read_from_MM && !write_to_MM;
  assign mm_data  = drive_en ? mem[addr_q] : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: directed bench for main_memory. Instance u_mm0 uses
// WAIT_STATES=2, instance u_mm1 uses WAIT_STATES=0. Stimulus pushes the
// expected completion into a per-instance queue, and a negedge monitor pops
// and compares whenever mm_ready is seen.
module tb_main_memory;

  typedef struct {
    logic        is_read;
    logic [15:0] data;
    logic        want_z;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  addr0 = '0, addr1 = '0;
  logic        rd0 = 1'b0, wr0 = 1'b0, rd1 = 1'b0, wr1 = 1'b0;
  logic        drv0 = 1'b0, drv1 = 1'b0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  wire  [15:0] bus0, bus1;
  logic        busy0, ready0, err0, busy1, ready1, err1;
  logic [15:0] mdr0, mdr1;
  logic        mon_on = 1'b0;

  int checks = 0;
  int errors = 0;
  int err_exp0 = 0;
  int err_seen0 = 0;

  exp_t sb0[$];
  exp_t sb1[$];
  exp_t e0, e1;

  assign bus0 = drv0 ? wdata0 : 16'hzzzz;
  assign bus1 = drv1 ? wdata1 : 16'hzzzz;

  main_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(2)) u_mm0 (
    .clk(clk), .reset(reset), .mar_addr(addr0), .mm_data(bus0),
    .read_from_MM(rd0), .write_to_MM(wr0),
    .mm_busy(busy0), .mm_ready(ready0), .mm_error(err0)
  );

  main_memory #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .WAIT_STATES(0)) u_mm1 (
    .clk(clk), .reset(reset), .mar_addr(addr1), .mm_data(bus1),
    .read_from_MM(rd1), .write_to_MM(wr1),
    .mm_busy(busy1), .mm_ready(ready1), .mm_error(err1)
  );

  always #5 clk = ~clk;

  // MDR model: latches the wire on the completing edge of a read.
  always @(posedge clk) begin
    if (ready0 && rd0) mdr0 <= bus0;
    if (ready1 && rd1) mdr1 <= bus1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor, sampling mid-cycle.
  always @(negedge clk) begin
    if (mon_on) begin
      if (ready0) begin
        check("ready0_expected", sb0.size() != 0, 1);
        if (sb0.size() != 0) begin
          e0 = sb0.pop_front();
          if (e0.is_read && e0.want_z) check("rd0_bus_z", bus0 === 16'hzzzz, 1);
          else if (e0.is_read)         check("rd0_data", bus0, e0.data);
        end
      end else if (!drv0) begin
        check("bus0_released", bus0 === 16'hzzzz, 1);
      end
      if (ready1) begin
        check("ready1_expected", sb1.size() != 0, 1);
        if (sb1.size() != 0) begin
          e1 = sb1.pop_front();
          if (e1.is_read) check("rd1_data", bus1, e1.data);
        end
      end else if (!drv1) begin
        check("bus1_released", bus1 === 16'hzzzz, 1);
      end
      if (err0) begin
        err_seen0++;
        check("err0_expected", err_seen0 <= err_exp0, 1);
      end
      check("err1_quiet", err1, 0);
    end
  end

  // Full write on u_mm0 with cycle-exact busy/ready checks.
  task automatic wr_txn0(input logic [7:0] a, input logic [15:0] d);
    check("wr_idle_busy", busy0, 0);
    addr0 = a; wdata0 = d; drv0 = 1'b1; wr0 = 1'b1;
    sb0.push_back('{1'b0, d, 1'b0});
    for (int c = 1; c <= 4; c++) begin
      tick();
      check("wr_busy", busy0, 1);
      check("wr_ready", ready0, (c == 3) ? 1 : 0);
    end
    wr0 = 1'b0; drv0 = 1'b0;
    tick();
    check("wr_back_idle", busy0, 0);
  endtask

  // Full read on u_mm0; extra holds the request in HOLD for more cycles.
  task automatic rd_txn0(input logic [7:0] a, input logic [15:0] d, input int extra);
    check("rd_idle_busy", busy0, 0);
    addr0 = a; rd0 = 1'b1;
    sb0.push_back('{1'b1, d, 1'b0});
    for (int c = 1; c <= 4 + extra; c++) begin
      tick();
      check("rd_busy", busy0, 1);
      check("rd_ready", ready0, (c == 3) ? 1 : 0);
      if (c == 4) check("rd_mdr", mdr0, d);
    end
    rd0 = 1'b0;
    tick();
    check("rd_back_idle", busy0, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete by %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    tick(); tick();
    check("rst_busy0", busy0, 0);   check("rst_ready0", ready0, 0);
    check("rst_err0", err0, 0);     check("rst_busy1", busy1, 0);
    check("rst_ready1", ready1, 0); check("rst_bus0_z", bus0 === 16'hzzzz, 1);
    reset = 1'b0;
    mon_on = 1'b1;
    tick();

    // Write then read back, then a read held for 10 cycles in HOLD.
    wr_txn0(8'h12, 16'hBEEF);
    rd_txn0(8'h12, 16'hBEEF, 0);
    rd_txn0(8'h12, 16'hBEEF, 10);

    // Write aborted in its final wait cycle must not commit.
    wr_txn0(8'h05, 16'hAAAA);
    addr0 = 8'h05; wdata0 = 16'h1234; drv0 = 1'b1; wr0 = 1'b1;
    tick(); check("abort_c1_busy", busy0, 1);
    tick(); check("abort_c2_busy", busy0, 1);
    wr0 = 1'b0; drv0 = 1'b0;
    tick(); check("abort_idle", busy0, 0); check("abort_no_ready", ready0, 0);
    rd_txn0(8'h05, 16'hAAAA, 0);

    // Read and write together: one-cycle error pulse, no transaction.
    addr0 = 8'h05; rd0 = 1'b1; wr0 = 1'b1; err_exp0++;
    tick(); check("both_err_c1", err0, 1); check("both_busy_c1", busy0, 1);
    tick(); check("both_err_c2", err0, 0); check("both_ready_c2", ready0, 0);
    rd0 = 1'b0; wr0 = 1'b0;
    tick(); check("both_idle", busy0, 0);
    rd_txn0(8'h05, 16'hAAAA, 0);

    // Opposite request mid-read: read still completes, wire stays released.
    addr0 = 8'h12; rd0 = 1'b1;
    sb0.push_back('{1'b1, 16'h0000, 1'b1});
    tick(); wr0 = 1'b1;
    tick();
    tick(); check("opp_ready", ready0, 1);
    tick(); check("opp_hold", busy0, 1);
    rd0 = 1'b0; wr0 = 1'b0;
    tick(); check("opp_idle", busy0, 0);

    // Address change after acceptance is ignored.
    addr0 = 8'h12; rd0 = 1'b1;
    sb0.push_back('{1'b1, 16'hBEEF, 1'b0});
    tick(); addr0 = 8'h05;
    tick();
    tick(); check("addr_chg_ready", ready0, 1);
    tick(); check("addr_chg_mdr", mdr0, 16'hBEEF);
    rd0 = 1'b0;
    tick();

    // Reset during WR_WAIT abandons the write.
    wr_txn0(8'hFF, 16'h0F0F);
    addr0 = 8'hFF; wdata0 = 16'h5555; drv0 = 1'b1; wr0 = 1'b1;
    tick(); check("rstw_busy", busy0, 1);
    reset = 1'b1;
    tick();
    check("rstw_busy0", busy0, 0); check("rstw_ready0", ready0, 0);
    check("rstw_err0", err0, 0);
    reset = 1'b0; wr0 = 1'b0; drv0 = 1'b0;
    tick();
    rd_txn0(8'hFF, 16'h0F0F, 0);

    // Zero-wait-state instance: completion one cycle after acceptance.
    check("ws0_idle", busy1, 0);
    addr1 = 8'hFF; wdata1 = 16'h5555; drv1 = 1'b1; wr1 = 1'b1;
    sb1.push_back('{1'b0, 16'h5555, 1'b0});
    tick(); check("ws0_wr_ready", ready1, 1); check("ws0_wr_busy", busy1, 1);
    tick(); check("ws0_wr_hold", ready1, 0);
    wr1 = 1'b0; drv1 = 1'b0;
    tick(); check("ws0_wr_idle", busy1, 0);
    addr1 = 8'hFF; rd1 = 1'b1;
    sb1.push_back('{1'b1, 16'h5555, 1'b0});
    tick(); check("ws0_rd_ready", ready1, 1);
    tick(); check("ws0_rd_hold", ready1, 0); check("ws0_rd_mdr", mdr1, 16'h5555);
    rd1 = 1'b0;
    tick(); check("ws0_rd_idle", busy1, 0);

    tick();
    check("sb0_drained", sb0.size(), 0);
    check("sb1_drained", sb1.size(), 0);
    check("err0_count", err_seen0, err_exp0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
